time_display_scanner: RTL and testbench
=======================================

Name: time_display_scanner

Overview:
- Consumer side of the stopwatch/clock time bus: takes binary hour/minute/second values and drives a 6-digit, time-multiplexed, common-anode 7-segment display (HH.MM.SS).
- Performs binary-to-BCD conversion, one-hot digit scanning, frame snapshotting (no tearing), and set-mode field blinking.
- Sits between the time-keeping counters/controller and the board display pins.

Parameters:
- SCAN_DIV, 1000, clock cycles each digit stays lit (must be >=2).
- BLINK_DIV, 250, completed frames per blink-phase toggle (must be >=1).

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  reset, asynchronous, active-high
- i_sec  input  6  seconds, binary; legal range 0..59
- i_min  input  6  minutes, binary; legal range 0..59
- i_hr  input  5  hours, binary; legal range 0..23
- i_blink_sel  input  3  field blink select, one-hot: [0] sec, [1] min, [2] hr; 000 = none
- o_an  output  6  digit enables, active-low; bit k = digit k (0 = sec ones, 5 = hr tens)
- o_seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- o_dp  output  1  decimal point, active-low

Behaviour:
- Reset (async, i_rst=1):
  - digit index d=0; scan counter=0; frame counter=0; blink phase=visible.
  - Snapshot registers=0.
  - o_an=6'b111111, o_seg=7'b1111111, o_dp=1.
- Scan counter counts 0..SCAN_DIV-1. At the terminal count it returns to 0 and d advances 0->1->...->5->0.
- Snapshot:
  - i_sec, i_min, i_hr and i_blink_sel are captured on the edge where d goes 5->0.
  - They are also captured on the first clock edge after reset release.
  - Mid-frame input changes never appear until the next frame.
- Blink:
  - The frame counter increments on every 5->0 wrap.
  - When it reaches BLINK_DIV-1 it clears and the blink phase toggles.
  - In the hidden phase, both digits of each field selected in the snapshot are blanked.
  - If the snapshot blink select is 000, the phase is ignored.
- BCD conversion (per field, combinational, compare-subtract):
  - tens = value/10, ones = value%10.
  - A sec/min value >59 or an hr value >23 displays dash (segment g only) on both digits of that field.
- Digit map: d0 sec ones, d1 sec tens, d2 min ones, d3 min tens, d4 hr ones, d5 hr tens. Leading zeros are shown (e.g. "05").
- Decimal point: lit (o_dp=0) on d2 and d4 (separators); otherwise 1. It is not affected by blink.
- Outputs are registered:
  - o_an, o_seg and o_dp reflect the d value present before the clock edge, i.e. one cycle of latency after d changes.
  - o_an is one-hot-low at all times after the first post-reset edge; exactly one digit is enabled.
- Blank digit: the anode is still driven for that slot, but o_seg=7'b1111111 and o_dp is unchanged.
- Reset mid-scan: all state returns to reset values immediately. Outputs go dark without waiting for a clock edge.

Decomposition:
- Shared package (time_disp_pkg):
  - Segment constants: SEG_0..SEG_9, SEG_DASH=7'b0111111, SEG_BLANK=7'b1111111.
  - Field index constants: FLD_SEC=0, FLD_MIN=1, FLD_HR=2.
  - Digit count constant NUM_DIGITS=6.
- Sub-module seg7_encoder: combinational, 4-bit code input (0..9, 10 = dash, 15 = blank) to 7-bit active-low segments. Instantiated once on the muxed digit.
- BCD split is a local function.

Test Plan:
- Reset -> o_an=111111, o_seg=1111111, o_dp=1 asynchronously. First post-release edge -> o_an=111110.
- SCAN_DIV=4, inputs hr=12 min=34 sec=56 -> over 24 cycles:
  - o_an walks 111110..011111, each for 4 cycles.
  - o_seg shows SEG_6,5,4,3,2,1.
  - o_dp=0 only on d2 and d4.
- Change sec 56->57 while d=3 -> d0/d1 still show 56 for the remainder of that frame; 57 appears from the next frame.
- sec=60, hr=24 -> d0, d1, d4, d5 show SEG_DASH; min digits are normal.
- BLINK_DIV=2, i_blink_sel=010 -> min digits show SEG_BLANK for 2 frames, then visible for 2 frames, repeating. Sec and hr are unaffected.
- Assert i_rst while d=3 mid-count -> outputs go dark immediately. After release, the scan restarts at d0 with a fresh snapshot.

Source files
------------

// File: rtl/time_disp_pkg.sv
// Shared constants for the time display: active-low segment patterns {g,f,e,d,c,b,a},
// field indices and the digit-code values understood by seg7_encoder.
package time_disp_pkg;

   localparam int NUM_DIGITS = 6;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] CODE_DASH  = 4'd10;
   localparam logic [3:0] CODE_BLANK = 4'd15;

   typedef enum logic [1:0] {
      FLD_SEC = 2'd0,
      FLD_MIN = 2'd1,
      FLD_HR  = 2'd2
   } field_e;

endpackage

// File: rtl/seg7_encoder.sv
// Digit code to active-low segments: 0..9 decimal, 10 dash, anything else blank.
module seg7_encoder
   import time_disp_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (code)
         4'd0:      seg = SEG_0;
         4'd1:      seg = SEG_1;
         4'd2:      seg = SEG_2;
         4'd3:      seg = SEG_3;
         4'd4:      seg = SEG_4;
         4'd5:      seg = SEG_5;
         4'd6:      seg = SEG_6;
         4'd7:      seg = SEG_7;
         4'd8:      seg = SEG_8;
         4'd9:      seg = SEG_9;
         CODE_DASH: seg = SEG_DASH;
         default:   seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/time_display_scanner.sv
// Six-digit multiplexed HH.MM.SS display driver with per-frame input snapshot and
// set-mode field blinking; segment/anode/dp outputs are registered.
module time_display_scanner
   import time_disp_pkg::*;
#(
   parameter int SCAN_DIV  = 1000,
   parameter int BLINK_DIV = 250
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [5:0] i_sec,
   input  logic [5:0] i_min,
   input  logic [4:0] i_hr,
   input  logic [2:0] i_blink_sel,
   output logic [5:0] o_an,
   output logic [6:0] o_seg,
   output logic       o_dp
);

   localparam int SCAN_W  = $clog2(SCAN_DIV);
   localparam int FRAME_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [SCAN_W-1:0]  scan_cnt;
   logic [2:0]         digit;
   logic [FRAME_W-1:0] frame_cnt;
   logic               blink_hidden;
   logic               primed;
   logic [5:0]         snap_sec;
   logic [5:0]         snap_min;
   logic [4:0]         snap_hr;
   logic [2:0]         snap_blink;

   logic               scan_tc;
   logic               frame_wrap;
   logic [5:0]         fval;
   logic               over;
   logic               hide;
   logic [7:0]         bcd;
   logic [3:0]         code_p0;
   logic [6:0]         seg_p0;
   logic [5:0]         an_p0;
   logic               dp_p0;

   // Compare-subtract split of 0..63 into {tens, ones}.
   function automatic logic [7:0] bcd_split(input logic [5:0] value);
      logic [5:0] rem;
      logic [3:0] tens;
      rem  = value;
      tens = 4'd0;
      if (rem >= 6'd40) begin rem = rem - 6'd40; tens = tens + 4'd4; end
      if (rem >= 6'd20) begin rem = rem - 6'd20; tens = tens + 4'd2; end
      if (rem >= 6'd10) begin rem = rem - 6'd10; tens = tens + 4'd1; end
      return {tens, rem[3:0]};
   endfunction

   assign scan_tc    = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
   assign frame_wrap = scan_tc && (digit == 3'd5);

   // Stage p0: select the field for the current digit and build its code.
   always_comb begin
      fval = 6'd0;
      over = 1'b0;
      hide = 1'b0;
      case (digit[2:1])
         FLD_SEC: begin fval = snap_sec;         over = (snap_sec > 6'd59); hide = snap_blink[0]; end
         FLD_MIN: begin fval = snap_min;         over = (snap_min > 6'd59); hide = snap_blink[1]; end
         FLD_HR:  begin fval = {1'b0, snap_hr};  over = (snap_hr > 5'd23);  hide = snap_blink[2]; end
         default: begin fval = 6'd0;             over = 1'b0;               hide = 1'b0;          end
      endcase
      bcd     = bcd_split(fval);
      code_p0 = digit[0] ? bcd[7:4] : bcd[3:0];
      if (over)
         code_p0 = CODE_DASH;
      if (blink_hidden && hide)
         code_p0 = CODE_BLANK;
      an_p0 = ~(6'b000001 << digit);
      dp_p0 = ~((digit == 3'd2) || (digit == 3'd4));
   end

   seg7_encoder u_enc (
      .code (code_p0),
      .seg  (seg_p0)
   );

   // Stage p1: output registers plus scan, frame and snapshot state.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         scan_cnt     <= '0;
         digit        <= 3'd0;
         frame_cnt    <= '0;
         blink_hidden <= 1'b0;
         primed       <= 1'b0;
         snap_sec     <= 6'd0;
         snap_min     <= 6'd0;
         snap_hr      <= 5'd0;
         snap_blink   <= 3'd0;
         o_an         <= 6'b111111;
         o_seg        <= SEG_BLANK;
         o_dp         <= 1'b1;
      end else begin
         o_an   <= an_p0;
         o_seg  <= seg_p0;
         o_dp   <= dp_p0;
         primed <= 1'b1;
         if (scan_tc) begin
            scan_cnt <= '0;
            digit    <= (digit == 3'd5) ? 3'd0 : digit + 3'd1;
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
         // Capture only at frame boundaries so a frame never mixes old and new time.
         if (!primed || frame_wrap) begin
            snap_sec   <= i_sec;
            snap_min   <= i_min;
            snap_hr    <= i_hr;
            snap_blink <= i_blink_sel;
         end
         if (frame_wrap) begin
            if (frame_cnt == FRAME_W'(BLINK_DIV - 1)) begin
               frame_cnt    <= '0;
               blink_hidden <= ~blink_hidden;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_time_display_scanner.sv
// Bench for time_display_scanner: table vectors, hand-written frame/blink/reset
// sequences and randomized inputs checked every cycle against a frame-level model.
module tb_time_display_scanner;

   localparam int SCAN  = 4;
   localparam int BLINK = 2;
   localparam int FR    = 6 * SCAN;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [5:0] sec = 6'd0;
   logic [5:0] min = 6'd0;
   logic [4:0] hr  = 5'd0;
   logic [2:0] blink_sel = 3'd0;
   logic [5:0] an;
   logic [6:0] seg;
   logic       dp;

   int tests = 0;
   int fails = 0;
   int n = 0;
   int m_sec = 0, m_min = 0, m_hr = 0, m_sel = 0;

   logic [6:0] seg_tbl [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   typedef struct {
      int         s;
      int         m;
      int         h;
      int         d;
      logic [6:0] seg;
   } vec_t;
   vec_t vecs [18];

   time_display_scanner #(.SCAN_DIV(SCAN), .BLINK_DIV(BLINK)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_sec       (sec),
      .i_min       (min),
      .i_hr        (hr),
      .i_blink_sel (blink_sel),
      .o_an        (an),
      .o_seg       (seg),
      .o_dp        (dp)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] model_seg(int s, int mi, int h, int sel, int d, bit hid);
      int v, lim, fld;
      fld = d / 2;
      v   = (fld == 0) ? s : (fld == 1) ? mi : h;
      lim = (fld == 2) ? 23 : 59;
      if (hid && (((sel >> fld) & 1) == 1)) return 7'h7f;
      if (v > lim) return 7'h3f;
      return seg_tbl[(d % 2 == 1) ? v / 10 : v % 10];
   endfunction

   task automatic check(string name, logic [13:0] got, logic [13:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s (edge %0d): got %h required %h", name, n, got, exp);
      end
   endtask

   // One clock edge; outputs at edge n show digit/frame derived from n, using the
   // snapshot taken at the previous frame start (edge 1, then every FR edges).
   task automatic step();
      int d, f;
      bit hid;
      logic [5:0] ean;
      logic [6:0] eseg;
      logic edp;
      @(posedge clk);
      n++;
      d    = ((n - 1) / SCAN) % 6;
      f    = (n - 1) / FR;
      hid  = ((f / BLINK) % 2) == 1;
      ean  = ~(6'b000001 << d);
      eseg = model_seg(m_sec, m_min, m_hr, m_sel, d, hid);
      edp  = (d == 2 || d == 4) ? 1'b0 : 1'b1;
      if (n == 1 || n % FR == 0) begin
         m_sec = int'(sec); m_min = int'(min); m_hr = int'(hr); m_sel = int'(blink_sel);
      end
      #1;
      check("scan", {an, seg, dp}, {ean, eseg, edp});
   endtask

   task automatic run_to(int target);
      while (n < target) step();
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      #2;
      check("reset_dark", {an, seg, dp}, {6'h3f, 7'h7f, 1'b1});
      @(posedge clk);
      #1;
      check("reset_hold", {an, seg, dp}, {6'h3f, 7'h7f, 1'b1});
      rst = 1'b0;
      n = 0; m_sec = 0; m_min = 0; m_hr = 0; m_sel = 0;
   endtask

   task automatic set_time(int h, int m, int s, int sel);
      hr = 5'(h); min = 6'(m); sec = 6'(s); blink_sel = 3'(sel);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] blank_pat;

      vecs[0]  = '{56, 34, 12, 0, 7'h02};
      vecs[1]  = '{56, 34, 12, 1, 7'h12};
      vecs[2]  = '{56, 34, 12, 2, 7'h19};
      vecs[3]  = '{56, 34, 12, 3, 7'h30};
      vecs[4]  = '{56, 34, 12, 4, 7'h24};
      vecs[5]  = '{56, 34, 12, 5, 7'h79};
      vecs[6]  = '{60, 34, 24, 0, 7'h3f};
      vecs[7]  = '{60, 34, 24, 1, 7'h3f};
      vecs[8]  = '{60, 34, 24, 2, 7'h19};
      vecs[9]  = '{60, 34, 24, 3, 7'h30};
      vecs[10] = '{60, 34, 24, 4, 7'h3f};
      vecs[11] = '{60, 34, 24, 5, 7'h3f};
      vecs[12] = '{ 9,  7,  5, 0, 7'h10};
      vecs[13] = '{ 9,  7,  5, 1, 7'h40};
      vecs[14] = '{ 9,  7,  5, 2, 7'h78};
      vecs[15] = '{ 9,  7,  5, 5, 7'h40};
      vecs[16] = '{59, 59, 23, 5, 7'h24};
      vecs[17] = '{59, 59, 23, 3, 7'h12};

      // Reset, then the first edge after release enables digit 0.
      apply_reset();
      set_time(12, 34, 56, 0);
      step();
      check("first_edge_an", {8'd0, an}, {8'd0, 6'b111110});

      // Table vectors: look at the second edge of the target digit's slot.
      foreach (vecs[i]) begin
         apply_reset();
         set_time(vecs[i].h, vecs[i].m, vecs[i].s, 0);
         run_to(vecs[i].d * SCAN + 2);
         check("table_seg", {7'd0, seg}, {7'd0, vecs[i].seg});
      end

      // Mid-frame change of seconds: takes effect only from the next frame.
      apply_reset();
      set_time(12, 34, 56, 0);
      run_to(3 * SCAN + 2);
      sec = 6'd57;
      run_to(FR - 1);
      check("midframe_hr_tens", {7'd0, seg}, {7'd0, 7'h79});
      run_to(FR + 2);
      check("midframe_new_ones", {7'd0, seg}, {7'd0, 7'h78});
      run_to(FR + SCAN + 2);
      check("midframe_new_tens", {7'd0, seg}, {7'd0, 7'h12});

      // Minute blinking: frames 2 and 3 hidden, others visible; hr untouched.
      apply_reset();
      set_time(12, 34, 56, 3'b010);
      blank_pat = 6'b001100;
      for (int f = 0; f < 6; f++) begin
         run_to(f * FR + 2 * SCAN + 2);
         check("blink_min", {7'd0, seg}, {7'd0, blank_pat[f] ? 7'h7f : 7'h19});
         run_to(f * FR + 4 * SCAN + 2);
         check("blink_hr", {7'd0, seg}, {7'd0, 7'h24});
      end

      // Reset in the middle of digit 3, then a fresh scan with new inputs.
      apply_reset();
      set_time(12, 34, 56, 0);
      run_to(3 * SCAN + 2);
      set_time(1, 2, 3, 0);
      apply_reset();
      step();
      step();
      check("restart_d0", {an, seg, dp}, {6'b111110, 7'h30, 1'b1});
      run_to(2 * SCAN + 2);
      check("restart_d2", {an, seg, dp}, {6'b111011, 7'h24, 1'b0});

      // Randomized inputs, occasionally out of range, changing at arbitrary cycles.
      for (int r = 0; r < 4; r++) begin
         apply_reset();
         for (int c = 0; c < 10 * FR; c++) begin
            if ($urandom_range(0, 7) == 0) begin
               if ($urandom_range(0, 7) == 0) begin
                  sec = 6'($urandom_range(0, 63));
                  min = 6'($urandom_range(0, 63));
                  hr  = 5'($urandom_range(0, 31));
               end else begin
                  sec = 6'($urandom_range(0, 59));
                  min = 6'($urandom_range(0, 59));
                  hr  = 5'($urandom_range(0, 23));
               end
               blink_sel = ($urandom_range(0, 3) == 0) ? 3'b000
                                                       : 3'(1 << $urandom_range(0, 2));
            end
            step();
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
